// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the main decoder/controller:
// opcode constants, the NOP encoding and the fetch-state type.
package instr_fetch_unit_pkg;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] LB    = 6'b100000;
    localparam logic [5:0] SB    = 6'b101000;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] J     = 6'b000010;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter with its next-PC mux and +4 adder. Redirect wins over
// sequential advance; redirect targets are forced to word alignment.
module fetch_pc_reg #(
    parameter int              AW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic [AW-1:0] next_pc,
    output logic [AW-1:0] pc_inc
);

    logic [AW-1:0] pc_reg;

    // Wraps modulo 2^AW by construction.
    assign pc_inc = pc_reg + AW'(4);

    always_comb begin
        next_pc = pc_reg;
        if (redirect) begin
            next_pc = redirect_pc & ~AW'(3);
        end else if (advance) begin
            next_pc = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= next_pc;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues word reads over req/ack, captures the result in
// the instruction register and offers it to decode over valid/ready.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   instr,
    output logic [5:0]    op,
    output logic [5:0]    funct,
    output logic [AW-1:0] instr_pc,
    output logic [AW-1:0] pc_plus4,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc
);

    fetch_state_t  state_reg, state_next;
    logic          kill_reg, kill_next;
    logic          imem_req_reg, imem_req_next;
    logic [AW-1:0] imem_addr_reg, imem_addr_next;
    logic          instr_valid_reg, instr_valid_next;
    logic [31:0]   instr_reg, instr_next;
    logic [AW-1:0] instr_pc_reg, instr_pc_next;
    logic [AW-1:0] pc_plus4_reg, pc_plus4_next;
    logic          advance;
    logic          ack_seen;
    logic [AW-1:0] next_pc;
    logic [AW-1:0] pc_inc;

    fetch_pc_reg #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .reset       (reset),
        .advance     (advance),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .next_pc     (next_pc),
        .pc_inc      (pc_inc)
    );

    assign ack_seen = imem_ack & imem_req_reg;

    always_comb begin
        state_next       = state_reg;
        kill_next        = kill_reg;
        imem_req_next    = imem_req_reg;
        imem_addr_next   = imem_addr_reg;
        instr_valid_next = instr_valid_reg;
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;
        pc_plus4_next    = pc_plus4_reg;
        advance          = 1'b0;
        case (state_reg)
            FETCH: begin
                // next_pc already reflects a same-cycle redirect.
                imem_req_next  = 1'b1;
                imem_addr_next = next_pc;
                state_next     = WAIT;
            end
            WAIT: begin
                if (ack_seen) begin
                    imem_req_next = 1'b0;
                    if (kill_reg || redirect) begin
                        kill_next  = 1'b0;
                        state_next = FETCH;
                    end else begin
                        // pc equals imem_addr here, so pc_inc is imem_addr+4.
                        advance          = 1'b1;
                        instr_next       = imem_rdata;
                        instr_pc_next    = imem_addr_reg;
                        pc_plus4_next    = pc_inc;
                        instr_valid_next = 1'b1;
                        state_next       = HOLD;
                    end
                end else if (redirect) begin
                    kill_next = 1'b1;
                end
            end
            HOLD: begin
                if (redirect || instr_ready) begin
                    instr_valid_next = 1'b0;
                    state_next       = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= FETCH;
            kill_reg        <= 1'b0;
            imem_req_reg    <= 1'b0;
            imem_addr_reg   <= RESET_PC;
            instr_valid_reg <= 1'b0;
            instr_reg       <= NOP_INSTR;
            instr_pc_reg    <= '0;
            pc_plus4_reg    <= AW'(4);
        end else begin
            state_reg       <= state_next;
            kill_reg        <= kill_next;
            imem_req_reg    <= imem_req_next;
            imem_addr_reg   <= imem_addr_next;
            instr_valid_reg <= instr_valid_next;
            instr_reg       <= instr_next;
            instr_pc_reg    <= instr_pc_next;
            pc_plus4_reg    <= pc_plus4_next;
        end
    end

    assign imem_req    = imem_req_reg;
    assign imem_addr   = imem_addr_reg;
    assign instr_valid = instr_valid_reg;
    assign instr       = instr_reg;
    assign op          = instr_reg[31:26];
    assign funct       = instr_reg[5:0];
    assign instr_pc    = instr_pc_reg;
    assign pc_plus4    = pc_plus4_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected request addresses and
// delivered instructions are queued by the stimulus and checked by a monitor.
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [31:0] pc;
        logic [31:0] plus4;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic        imem_ack_w;
    logic [31:0] imem_rdata_w;
    logic        instr_valid_w;
    logic        instr_ready_w;
    logic [31:0] instr_w;
    logic [5:0]  op_w;
    logic [5:0]  funct_w;
    logic [31:0] instr_pc_w;
    logic [31:0] pc_plus4_w;
    logic        redirect_w;
    logic [31:0] redirect_pc_w;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic [31:0] addr_q[$];

    instr_fetch_unit #(.AW(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .op(op), .funct(funct),
        .instr_pc(instr_pc), .pc_plus4(pc_plus4),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    instr_fetch_unit #(.AW(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
        .instr_valid(instr_valid_w), .instr_ready(instr_ready_w),
        .instr(instr_w), .op(op_w), .funct(funct_w),
        .instr_pc(instr_pc_w), .pc_plus4(pc_plus4_w),
        .redirect(redirect_w), .redirect_pc(redirect_pc_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 50) begin
            tick();
            n++;
        end
        if (!imem_req) begin
            n_cmp++;
            n_fail++;
            $display("FAIL req_timeout: imem_req=%b after %0d cycles, expected 1", imem_req, n);
        end
    endtask

    // Memory answers lat cycles after the request is first visible.
    task automatic mem_respond(input int lat, input logic [31:0] data);
        wait_req();
        repeat (lat) tick();
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk("valid_after_ack", 32'(instr_valid), 32'd1);
    endtask

    // Monitor: checks every new request and every newly presented instruction.
    initial begin : monitor
        logic        prev_req;
        logic        prev_valid;
        logic        prev_ready;
        logic [31:0] held_addr;
        logic [31:0] held_instr;
        logic [31:0] held_pc;
        exp_t        e;
        logic [31:0] a;
        prev_req   = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        held_addr  = '0;
        held_instr = '0;
        held_pc    = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_req   = 1'b0;
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (imem_req && instr_valid) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL req_valid_overlap: imem_req=1 instr_valid=1, expected not both");
                end
                if (imem_req && !prev_req) begin
                    if (addr_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_req: imem_addr=%h, expected no request", imem_addr);
                    end else begin
                        a = addr_q.pop_front();
                        $display("req   addr=%h expected=%h", imem_addr, a);
                        chk("req_addr", imem_addr, a);
                    end
                    held_addr = imem_addr;
                end else if (imem_req && prev_req) begin
                    chk("req_addr_stable", imem_addr, held_addr);
                end
                if (instr_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_instr: instr=%h, expected no delivery", instr);
                    end else begin
                        e = exp_q.pop_front();
                        $display("instr %h pc=%h expected %h pc=%h", instr, instr_pc, e.instr, e.pc);
                        chk("instr", instr, e.instr);
                        chk("op", 32'(op), 32'(e.op));
                        chk("funct", 32'(funct), 32'(e.funct));
                        chk("instr_pc", instr_pc, e.pc);
                        chk("pc_plus4", pc_plus4, e.plus4);
                    end
                    held_instr = instr;
                    held_pc    = instr_pc;
                end else if (instr_valid && prev_valid && !prev_ready) begin
                    chk("instr_stable", instr, held_instr);
                    chk("instr_pc_stable", instr_pc, held_pc);
                end
                prev_req   = imem_req;
                prev_valid = instr_valid;
                prev_ready = instr_ready;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        instr_ready   = 1'b1;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        imem_ack_w    = 1'b0;
        imem_rdata_w  = 32'h0;
        instr_ready_w = 1'b1;
        redirect_w    = 1'b0;
        redirect_pc_w = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_funct", 32'(funct), 32'd0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_w_imem_addr", imem_addr_w, 32'hFFFF_FFFC);

        // 1: basic fetch, ack one cycle after request
        addr_q.push_back(32'h0);
        exp_q.push_back('{32'h2008_0005, 6'b001000, 6'd5, 32'h0, 32'h4});
        tick();
        reset = 1'b1;
        mem_respond(1, 32'h2008_0005);
        tick();

        // 2: five-cycle memory latency, decode stalls three cycles
        addr_q.push_back(32'h4);
        exp_q.push_back('{32'h80A2_0007, 6'b100000, 6'd7, 32'h4, 32'h8});
        instr_ready = 1'b0;
        mem_respond(5, 32'h80A2_0007);
        repeat (3) tick();
        instr_ready = 1'b1;
        tick();
        chk("stall_release_valid", 32'(instr_valid), 32'd0);

        // 3: redirect while waiting, stale data acked later
        addr_q.push_back(32'h8);
        addr_q.push_back(32'h40);
        wait_req();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect    = 1'b0;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk("kill_no_valid", 32'(instr_valid), 32'd0);
        exp_q.push_back('{32'h1022_0003, 6'b000100, 6'd3, 32'h40, 32'h44});
        mem_respond(1, 32'h1022_0003);
        tick();

        // 4: redirect to unaligned 0x103 on the ack cycle
        addr_q.push_back(32'h44);
        addr_q.push_back(32'h100);
        wait_req();
        tick();
        imem_ack    = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        tick();
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        chk("ack_redirect_no_valid", 32'(instr_valid), 32'd0);
        exp_q.push_back('{32'h0800_0010, 6'b000010, 6'h10, 32'h100, 32'h104});
        instr_ready = 1'b0;
        mem_respond(2, 32'h0800_0010);

        // 5: redirect in HOLD with ready high
        addr_q.push_back(32'h80);
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        chk("hold_redirect_drop", 32'(instr_valid), 32'd0);
        exp_q.push_back('{32'h0085_1020, 6'b000000, 6'h20, 32'h80, 32'h84});
        mem_respond(1, 32'h0085_1020);
        addr_q.push_back(32'h84);
        tick();

        // 6: asynchronous reset while a request is outstanding
        wait_req();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_req", 32'(imem_req), 32'd0);
        chk("async_rst_valid", 32'(instr_valid), 32'd0);
        chk("async_rst_addr", imem_addr, 32'h0);
        tick();
        reset = 1'b1;
        addr_q.push_back(32'h0);
        exp_q.push_back('{32'h2008_0005, 6'b001000, 6'd5, 32'h0, 32'h4});
        mem_respond(1, 32'h2008_0005);
        addr_q.push_back(32'h4);
        tick();
        wait_req();
        tick();

        // 7: PC wrap on the instance reset to 0xFFFF_FFFC
        chk("wrap_req", 32'(imem_req_w), 32'd1);
        chk("wrap_req_addr", imem_addr_w, 32'hFFFF_FFFC);
        imem_ack_w   = 1'b1;
        imem_rdata_w = 32'h2008_FFFF;
        tick();
        imem_ack_w   = 1'b0;
        imem_rdata_w = 32'h0;
        $display("wrap  instr %h pc=%h plus4=%h", instr_w, instr_pc_w, pc_plus4_w);
        chk("wrap_valid", 32'(instr_valid_w), 32'd1);
        chk("wrap_instr", instr_w, 32'h2008_FFFF);
        chk("wrap_op", 32'(op_w), 32'h08);
        chk("wrap_funct", 32'(funct_w), 32'h3F);
        chk("wrap_instr_pc", instr_pc_w, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4_w, 32'h0);
        tick();
        chk("wrap_consumed", 32'(instr_valid_w), 32'd0);
        tick();
        chk("wrap_next_req", 32'(imem_req_w), 32'd1);
        chk("wrap_next_addr", imem_addr_w, 32'h0);

        repeat (3) tick();
        chk("addr_q_left", 32'(addr_q.size()), 32'd0);
        chk("exp_q_left", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the main decoder/controller.
- Owns the program counter and fetches 32-bit instructions from a multi-cycle instruction memory over a req/ack handshake.
- Holds each instruction in an instruction register and presents it with op/funct fields to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute.

Parameters:
- AW, 32, PC and instruction-memory byte-address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset (low 2 bits must be 0).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- imem_req  out  1  instruction-memory read request, registered
- imem_addr  out  AW  read address, word-aligned, registered
- imem_ack  in  1  memory response valid; only meaningful while imem_req=1
- imem_rdata  in  32  instruction word, valid with imem_ack
- instr_valid  out  1  instruction register holds a deliverable instruction
- instr_ready  in  1  decode accepts the instruction this cycle
- instr  out  32  instruction register
- op  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- instr_pc  out  AW  address of instr
- pc_plus4  out  AW  instr_pc+4, for branch-target and jump computation
- redirect  in  1  take redirect_pc as next fetch address
- redirect_pc  in  AW  target; bits [1:0] ignored (forced to 00)

Behaviour:
- Reset (async assert, sync-safe deassert by system):
  - pc=RESET_PC; state=FETCH; imem_req=0; imem_addr=RESET_PC; instr_valid=0.
  - instr=32'h0 (NOP), so op=0 and funct=0; instr_pc=0; pc_plus4=4; kill=0.
- States: FETCH, WAIT, HOLD.
- FETCH (one cycle):
  - Next cycle: imem_req=1, imem_addr=pc; go to WAIT.
  - If redirect this cycle: pc<=redirect_pc, and the request uses redirect_pc.
- WAIT:
  - imem_req and imem_addr held stable until imem_ack.
  - A request is never withdrawn; ack may arrive at earliest the cycle after req is seen high.
  - On ack with kill=0 and redirect=0: instr<=imem_rdata, instr_pc<=imem_addr, pc<=imem_addr+4, imem_req<=0, instr_valid<=1; go to HOLD. Fetch latency from FETCH entry to instr_valid = 2 + memory wait cycles.
  - Redirect with no ack: pc<=redirect_pc, kill<=1; stay in WAIT.
  - Ack with kill=1 or redirect=1: data discarded, kill<=0, imem_req<=0; go to FETCH. On same-cycle redirect+ack, pc<=redirect_pc.
  - Multiple redirects while waiting: last one wins.
- HOLD:
  - instr_valid=1; instr/op/funct/instr_pc stable until handshake.
  - instr_valid&instr_ready: instr_valid<=0; go to FETCH at pc.
  - Redirect (with or without ready): instr_valid<=0, pc<=redirect_pc; go to FETCH. With ready=1 the instruction counts as consumed.
  - instr register retains its last value after consumption; no re-clear to NOP.
- Arithmetic: pc+4 modulo 2^AW (0xFFFF_FFFC -> 0x0000_0000); no overflow flag.
- Reset mid-transaction: request dropped immediately, in-flight ack ignored, restart from RESET_PC. The memory side must tolerate an abandoned request.
- instr_valid never asserts in the same cycle as imem_req.

Decomposition:
- Shared package (also used by the controller):
  - opcode constants RTYPE 6'b000000, ADDI 6'b001000, LB 6'b100000, SB 6'b101000, BEQ 6'b000100, J 6'b000010
  - NOP_INSTR 32'h0
  - fetch-state typedef {FETCH, WAIT, HOLD}
- One natural sub-module: fetch_pc_reg. It holds the PC register, the next-PC mux (RESET_PC / pc+4 / redirect_pc with [1:0] cleared) and the +4 adder.
- FSM, kill flag and instruction register stay in instr_fetch_unit.

Test Plan:
- Reset release, memory acks 1 cycle after req, rdata 0x20080005, ready=1 -> imem_addr=0x0, instr_valid rises 2 cycles after req, op=6'b001000, instr_pc=0x0, pc_plus4=0x4; next request addr=0x4.
- Ack latency 5 cycles, then hold instr_ready=0 for 3 cycles -> imem_addr stable throughout wait; instr/op/funct/instr_pc unchanged while valid&!ready; exactly one next fetch after ready.
- Redirect to 0x40 in WAIT, ack 2 cycles later with 0xDEADBEEF -> 0xDEADBEEF never appears on instr; next request at 0x40; delivered instr_pc=0x40.
- Redirect to 0x103 in the same cycle as ack -> data discarded; next imem_addr=0x100.
- Redirect to 0x80 in HOLD with instr_ready=1 -> instr_valid drops next cycle; next fetch address 0x80, not instr_pc+4.
- PC wrap: RESET_PC=0xFFFF_FFFC, one delivered instr -> pc_plus4=0x0; next request addr=0x0. Async reset asserted in WAIT -> imem_req=0 and instr_valid=0 immediately.
